membus_master: RTL and testbench

Processor-side memory bus master for the PDP-6 membus. It turns a single-word client request (read, write, or read-modify-write) into the membus level/pulse handshake that the core memory port expects: rq_cyc/sel/ma/rd_rq/wr_rq, addr_ack, rd_rs, mb_in/mb_out, wr_rs. It sits directly upstream of one core161c processor port (p0..p3) and drives that port's membus wires. It adds per-phase timeouts so that a missing or nonexistent memory reports an error instead of hanging the processor.

---
 rtl/membus_pkg.sv | 34 +++
 rtl/membus_tmo.sv | 41 ++++
 rtl/membus_master.sv | 256 +++++++++++++++++++++++++
 tb/tb_membus_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// membus_pkg
// Shared definitions for the PDP-6 membus master: client op encodings,
// error codes, master FSM state enum and the fast-memory address range.
// No ports; imported by membus_master and its testbench.

package membus_pkg;

    // Client request op; bit 0 = read phase, bit 1 = write phase
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_RMW  = 2'b11;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_NO_ACK = 2'b01;
    localparam logic [1:0] ERR_NO_RS  = 2'b10;

    // Words 0..15 live in fast memory when fmc_en is set
    localparam int FMC_WORDS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_WDAT,
        ST_WR,
        ST_FIN
    } state_e;

    function automatic logic is_fmc_addr(input logic [18:35] addr);
        return addr < 18'(FMC_WORDS);
    endfunction

endpackage

// File: rtl/membus_tmo.sv
// membus_tmo
// Loadable down-counter used as the per-phase timeout of the membus master.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            load load_val this cycle (takes effect on the next edge)
//   load_val        cycles-1 to count before expiring
//   expired         counter has reached zero (terminal count)

module membus_tmo #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/membus_master.sv
// membus_master
// Turns one client request (read / write / read-modify-write) into the
// PDP-6 membus level/pulse handshake toward one core memory port, with
// per-phase timeouts reported as err instead of hanging.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   fmc_en                          route words 0..15 to fast memory
//   req_valid/req_ready/req_op/req_addr   client request (ready only in IDLE)
//   wdata_valid/wdata               client write data
//   rd_valid/rdata                  read word, pulsed valid once
//   done/err/err_code               end-of-cycle pulse or error pulse + code
//   membus_*                        membus level/pulse wires to/from memory
//
// state | meaning
// IDLE  | waiting for a client request
// REQ   | rq_cyc raised, waiting for addr_ack (ack timeout running)
// RD    | address acknowledged, waiting for rd_rs (rs timeout running)
// WDAT  | RMW read done, waiting for client write data
// WR    | two cycles of mb_in, wr_rs in the second
// FIN   | cycle complete, done follows

module membus_master
    import membus_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4096,
    parameter int RS_TIMEOUT  = 4096,
    parameter int TMO_W       = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fmc_en,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [18:35] req_addr,
    input  logic         wdata_valid,
    input  logic [0:35]  wdata,
    output logic         rd_valid,
    output logic [0:35]  rdata,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code,
    output logic         membus_rq_cyc,
    output logic         membus_rd_rq,
    output logic         membus_wr_rq,
    output logic         membus_wr_rs,
    output logic         membus_fmc_select,
    output logic [18:21] membus_sel,
    output logic [21:35] membus_ma,
    output logic [0:35]  membus_mb_in,
    input  logic         membus_addr_ack,
    input  logic         membus_rd_rs,
    input  logic [0:35]  membus_mb_out
);

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [18:35]  addr_q, addr_d;
    logic          fmc_q, fmc_d;
    logic [0:35]   wdata_q, wdata_d;
    logic [0:35]   rdata_q, rdata_d;
    logic          wr_ph_q, wr_ph_d;
    logic          req_ready_q, req_ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          rq_cyc_q, rq_cyc_d;
    logic          rd_rq_q, rd_rq_d;
    logic          wr_rq_q, wr_rq_d;
    logic          wr_rs_q, wr_rs_d;
    logic          fmc_sel_q, fmc_sel_d;
    logic [18:21]  sel_q, sel_d;
    logic [21:35]  ma_q, ma_d;
    logic [0:35]   mb_in_q, mb_in_d;

    logic             tmo_load;
    logic [TMO_W-1:0] tmo_val;
    logic             tmo_expired;

    membus_tmo #(.W(TMO_W)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .load     (tmo_load),
        .load_val (tmo_val),
        .expired  (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        fmc_d       = fmc_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        wr_ph_d     = wr_ph_q;
        err_code_d  = err_code_q;
        req_ready_d = 1'b0;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wr_rs_d     = 1'b0;
        mb_in_d     = '0;
        tmo_load    = 1'b0;
        tmo_val     = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                // req_ready_q is low for one cycle after done/err
                if (req_ready_q && req_valid && req_op != OP_NONE) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    fmc_d       = fmc_en & is_fmc_addr(req_addr);
                    rdata_d     = '0;
                    err_code_d  = ERR_NONE;
                    if (req_op == OP_WR) begin
                        wdata_d = wdata;
                    end
                    req_ready_d = 1'b0;
                    tmo_load    = 1'b1;
                    tmo_val     = TMO_W'(ACK_TIMEOUT - 1);
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                rdata_d = rdata_q | membus_mb_out;
                if (membus_addr_ack) begin
                    if (op_q == OP_WR) begin
                        wr_ph_d = 1'b0;
                        mb_in_d = wdata_q;
                        state_d = ST_WR;
                    end else if (membus_rd_rs) begin
                        // fast memory may answer in the ack cycle itself
                        rd_valid_d = 1'b1;
                        state_d    = (op_q == OP_RMW) ? ST_WDAT : ST_FIN;
                    end else begin
                        tmo_load = 1'b1;
                        tmo_val  = TMO_W'(RS_TIMEOUT - 1);
                        state_d  = ST_RD;
                    end
                end else if (tmo_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_NO_ACK;
                    state_d    = ST_IDLE;
                end
            end
            ST_RD: begin
                rdata_d = rdata_q | membus_mb_out;
                if (membus_rd_rs) begin
                    rd_valid_d = 1'b1;
                    state_d    = (op_q == OP_RMW) ? ST_WDAT : ST_FIN;
                end else if (tmo_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_NO_RS;
                    state_d    = ST_IDLE;
                end
            end
            ST_WDAT: begin
                if (wdata_valid) begin
                    wdata_d = wdata;
                    mb_in_d = wdata;
                    wr_ph_d = 1'b0;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (!wr_ph_q) begin
                    mb_in_d = wdata_q;
                    wr_rs_d = 1'b1;
                    wr_ph_d = 1'b1;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus request levels are registered from the next state so they are
        // high exactly while the FSM sits in REQ.
        rq_cyc_d  = (state_d == ST_REQ);
        rd_rq_d   = rq_cyc_d & op_d[0];
        wr_rq_d   = rq_cyc_d & op_d[1];
        fmc_sel_d = rq_cyc_d & fmc_d;
        sel_d     = rq_cyc_d ? addr_d[18:21] : '0;
        ma_d      = rq_cyc_d ? addr_d[21:35] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            addr_q      <= '0;
            fmc_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wr_ph_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            rq_cyc_q    <= 1'b0;
            rd_rq_q     <= 1'b0;
            wr_rq_q     <= 1'b0;
            wr_rs_q     <= 1'b0;
            fmc_sel_q   <= 1'b0;
            sel_q       <= '0;
            ma_q        <= '0;
            mb_in_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            fmc_q       <= fmc_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            wr_ph_q     <= wr_ph_d;
            req_ready_q <= req_ready_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            rq_cyc_q    <= rq_cyc_d;
            rd_rq_q     <= rd_rq_d;
            wr_rq_q     <= wr_rq_d;
            wr_rs_q     <= wr_rs_d;
            fmc_sel_q   <= fmc_sel_d;
            sel_q       <= sel_d;
            ma_q        <= ma_d;
            mb_in_q     <= mb_in_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign rd_valid          = rd_valid_q;
    assign rdata             = rdata_q;
    assign done              = done_q;
    assign err               = err_q;
    assign err_code          = err_code_q;
    assign membus_rq_cyc     = rq_cyc_q;
    assign membus_rd_rq      = rd_rq_q;
    assign membus_wr_rq      = wr_rq_q;
    assign membus_wr_rs      = wr_rs_q;
    assign membus_fmc_select = fmc_sel_q;
    assign membus_sel        = sel_q;
    assign membus_ma         = ma_q;
    assign membus_mb_in      = mb_in_q;

endmodule

// File: tb/tb_membus_master.sv
// tb_membus_master
// Drives client transactions into membus_master against a simple core
// memory model and checks each against a transaction-level reference.

module tb_membus_master;
    import membus_pkg::*;

    localparam int ACK_T = 16;
    localparam int RS_T  = 24;

    logic         clk = 1'b0;
    logic         reset;
    logic         fmc_en;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [18:35] req_addr;
    logic         wdata_valid;
    logic [0:35]  wdata;
    logic         rd_valid;
    logic [0:35]  rdata;
    logic         done;
    logic         err;
    logic [1:0]   err_code;
    logic         membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs, membus_fmc_select;
    logic [18:21] membus_sel;
    logic [21:35] membus_ma;
    logic [0:35]  membus_mb_in;
    logic         membus_addr_ack, membus_rd_rs;
    logic [0:35]  membus_mb_out;

    membus_master #(.ACK_TIMEOUT(ACK_T), .RS_TIMEOUT(RS_T), .TMO_W(13)) dut (
        .clk(clk), .reset(reset), .fmc_en(fmc_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata(wdata),
        .rd_valid(rd_valid), .rdata(rdata), .done(done), .err(err), .err_code(err_code),
        .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq), .membus_wr_rq(membus_wr_rq),
        .membus_wr_rs(membus_wr_rs), .membus_fmc_select(membus_fmc_select),
        .membus_sel(membus_sel), .membus_ma(membus_ma), .membus_mb_in(membus_mb_in),
        .membus_addr_ack(membus_addr_ack), .membus_rd_rs(membus_rd_rs), .membus_mb_out(membus_mb_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0o expected=%0o (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:35] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    // Core memory contents (environment) and reference expectation
    logic [0:35] core_mem [int];
    logic [0:35] ref_mem  [int];
    logic        mute_rs  = 1'b0;
    logic        mem_busy = 1'b0;
    int          ack_cyc  = 0;

    function automatic logic [0:35] core_rd(input logic [18:35] a);
        return core_mem.exists(int'(a)) ? core_mem[int'(a)] : 36'd0;
    endfunction

    function automatic logic [0:35] ref_rd(input logic [18:35] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 36'd0;
    endfunction

    // Core memory model: no memory on sel 17, ignores fast-memory requests
    initial begin : core_model
        logic [18:35] a;
        logic         rd, wr, got;
        int           d;
        membus_addr_ack = 1'b0;
        membus_rd_rs    = 1'b0;
        membus_mb_out   = '0;
        forever begin
            tick();
            if (!reset && membus_rq_cyc && !membus_fmc_select && membus_sel != 4'hF) begin
                mem_busy = 1'b1;
                a  = {membus_sel, membus_ma[22:35]};
                rd = membus_rd_rq;
                wr = membus_wr_rq;
                repeat ($urandom_range(0, 3)) tick();
                membus_addr_ack = 1'b1;
                ack_cyc = cyc;
                if (rd && !mute_rs) begin
                    d = $urandom_range(0, 2);
                    if (d != 0) begin
                        tick();
                        membus_addr_ack = 1'b0;
                        repeat (d - 1) tick();
                        membus_mb_out = core_rd(a) & rnd36();
                        tick();
                    end
                    membus_rd_rs  = 1'b1;
                    membus_mb_out = core_rd(a);
                end
                tick();
                membus_addr_ack = 1'b0;
                membus_rd_rs    = 1'b0;
                membus_mb_out   = '0;
                if (wr && !(rd && mute_rs)) begin
                    got = 1'b0;
                    for (int i = 0; i < 80 && !got; i++) begin
                        if (membus_wr_rs) begin
                            core_mem[int'(a)] = membus_mb_in;
                            got = 1'b1;
                        end else begin
                            tick();
                        end
                    end
                end
                mem_busy = 1'b0;
            end
        end
    end

    // Bus-level protocol monitor
    logic        ack_prev = 1'b0;
    logic        wr_rs_prev = 1'b0;
    logic [0:35] mb_in_prev = '0;
    int          bus_viol = 0;
    always @(negedge clk) begin
        if (ack_prev) chk("rq_drop_after_ack", 64'(membus_rq_cyc), 64'd0);
        if (membus_wr_rs) begin
            chk("wr_rs_width", 64'(wr_rs_prev), 64'd0);
            chk("mb_in_stable", 64'(membus_mb_in), 64'(mb_in_prev));
        end
        if (!membus_rq_cyc && (membus_rd_rq || membus_wr_rq || membus_fmc_select ||
                               membus_sel != '0 || membus_ma != '0))
            bus_viol <= bus_viol + 1;
        ack_prev   <= membus_addr_ack && membus_rq_cyc;
        wr_rs_prev <= membus_wr_rs;
        mb_in_prev <= membus_mb_in;
    end

    task automatic run_txn(input logic [1:0] op, input logic [18:35] addr, input logic [0:35] wd,
                           input logic fmc, input int stall, input string tag);
        logic [1:0]  exp_ec;
        logic        exp_fmc;
        logic [0:35] exp_rd, got_rd;
        int          first_rq, rdv_cyc, end_cyc, n_rq, n_rdv, stall_cnt;
        logic        prev_rq, fmc_seen, fin, is_err, wv_sent, bus_busy;
        logic [1:0]  got_ec;

        exp_fmc = fmc && (addr < 18'd16);
        exp_ec  = ERR_NONE;
        if (exp_fmc || addr[18:21] == 4'hF) exp_ec = ERR_NO_ACK;
        else if (op[0] && mute_rs)          exp_ec = ERR_NO_RS;
        exp_rd = ref_rd(addr);

        for (int i = 0; i < 200 && mem_busy; i++) tick();
        for (int i = 0; i < 20 && !req_ready; i++) tick();
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);

        req_valid = 1'b1; req_op = op; req_addr = addr; wdata = wd; fmc_en = fmc;
        tick();
        req_valid = 1'b0; req_op = OP_NONE; wdata = rnd36(); fmc_en = 1'b0;
        chk({tag, ".rq_next"}, 64'(membus_rq_cyc), 64'd1);

        first_rq = -1; rdv_cyc = -1; end_cyc = -1; n_rq = 0; n_rdv = 0; stall_cnt = 0;
        prev_rq = 1'b0; fmc_seen = 1'b0; fin = 1'b0; is_err = 1'b0; wv_sent = 1'b0;
        got_rd = '0; got_ec = '0; bus_busy = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            if (wdata_valid) begin wdata_valid = 1'b0; wdata = rnd36(); end
            if (membus_rq_cyc && !prev_rq) begin
                n_rq++;
                if (first_rq < 0) first_rq = cyc;
            end
            prev_rq = membus_rq_cyc;
            if (membus_fmc_select) fmc_seen = 1'b1;
            if (rd_valid) begin
                n_rdv++; rdv_cyc = cyc; got_rd = rdata; stall_cnt = stall;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
            end
            if (op == OP_RMW && n_rdv > 0 && stall_cnt == 0 && !wv_sent) begin
                wdata_valid = 1'b1; wdata = wd; wv_sent = 1'b1;
            end
            if (done || err) begin
                fin = 1'b1; end_cyc = cyc; is_err = err; got_ec = err_code;
                bus_busy = membus_rq_cyc | membus_rd_rq | membus_wr_rq | membus_wr_rs |
                           (membus_mb_in != '0);
            end else begin
                tick();
            end
        end

        chk({tag, ".finished"}, 64'(fin), 64'd1);
        chk({tag, ".err"}, 64'(is_err), 64'(exp_ec != ERR_NONE));
        chk({tag, ".err_code"}, 64'(got_ec), 64'(exp_ec));
        chk({tag, ".fmc_sel"}, 64'(fmc_seen), 64'(exp_fmc));
        chk({tag, ".rq_once"}, 64'(n_rq), 64'd1);
        chk({tag, ".bus_quiet"}, 64'(bus_busy), 64'd0);
        chk({tag, ".ready_low"}, 64'(req_ready), 64'd0);
        if (exp_ec == ERR_NO_ACK) begin
            chk({tag, ".ack_tmo_cyc"}, 64'(end_cyc - first_rq), 64'(ACK_T));
        end else if (exp_ec == ERR_NO_RS) begin
            chk({tag, ".rs_tmo_cyc"}, 64'(end_cyc - ack_cyc), 64'(RS_T + 1));
        end else begin
            chk({tag, ".n_rd_valid"}, 64'(n_rdv), 64'(op[0]));
            if (op[0]) chk({tag, ".rdata"}, 64'(got_rd), 64'(exp_rd));
            if (op == OP_RD) chk({tag, ".done_lat"}, 64'(end_cyc - rdv_cyc), 64'd1);
            if (op[1]) begin
                ref_mem[int'(addr)] = wd;
                chk({tag, ".mem_after"}, 64'(core_rd(addr)), 64'(wd));
            end
        end
        tick();
        chk({tag, ".ready_back"}, 64'(req_ready), 64'd1);
    endtask

    logic [18:35] pool [8];
    int           n_wr_rs, n_done;

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset = 1'b1; fmc_en = 1'b0; req_valid = 1'b0; req_op = OP_NONE; req_addr = '0;
        wdata_valid = 1'b0; wdata = '0;
        pool[0] = 18'o000007; pool[1] = 18'o000012; pool[2] = 18'o000040; pool[3] = 18'o000100;
        pool[4] = 18'o001234; pool[5] = 18'o200000; pool[6] = 18'o377777; pool[7] = 18'o740010;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.rq_cyc", 64'(membus_rq_cyc), 64'd0);
        chk("rst.pulses", 64'({rd_valid, done, err, membus_wr_rs}), 64'd0);
        chk("rst.rdata", 64'(rdata), 64'd0);
        chk("rst.err_code", 64'(err_code), 64'd0);
        chk("rst.mb_in", 64'(membus_mb_in), 64'd0);

        // op 00 is ignored
        req_valid = 1'b1; req_op = OP_NONE; req_addr = 18'o1234;
        tick(); tick();
        req_valid = 1'b0;
        chk("nop.rq_cyc", 64'(membus_rq_cyc), 64'd0);
        chk("nop.ready", 64'(req_ready), 64'd1);

        core_mem[int'(18'o1234)] = 36'o123456701234;
        ref_mem[int'(18'o1234)]  = 36'o123456701234;
        run_txn(OP_RD, 18'o1234, '0, 1'b0, 0, "read1234");

        run_txn(OP_WR, 18'o40, 36'o777777777777, 1'b0, 0, "write40");
        run_txn(OP_RD, 18'o40, '0, 1'b0, 0, "readback40");

        core_mem[int'(18'o100)] = 36'd5;
        ref_mem[int'(18'o100)]  = 36'd5;
        run_txn(OP_RMW, 18'o100, 36'd6, 1'b0, 20, "rmw100");

        run_txn(OP_RD, 18'o740000, '0, 1'b0, 0, "nomem17");

        mute_rs = 1'b1;
        run_txn(OP_RD, 18'o200, '0, 1'b0, 0, "no_rd_rs");
        mute_rs = 1'b0;

        run_txn(OP_RD, 18'o7, '0, 1'b1, 0, "fmc7");

        // Reset while the master is in WR: the cycle is abandoned
        for (int i = 0; i < 200 && mem_busy; i++) tick();
        req_valid = 1'b1; req_op = OP_WR; req_addr = 18'o300; wdata = 36'o252525252525;
        tick();
        req_valid = 1'b0; req_op = OP_NONE;
        n_wr_rs = 0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (seen && !membus_rq_cyc) break;
                if (membus_rq_cyc) seen = 1'b1;
                tick();
            end
        end
        n_wr_rs += int'(membus_wr_rs);
        reset = 1'b1;
        tick();
        chk("rstwr.mb_in", 64'(membus_mb_in), 64'd0);
        chk("rstwr.ready", 64'(req_ready), 64'd1);
        tick();
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            n_wr_rs += int'(membus_wr_rs);
            n_done  += int'(done) + int'(err);
            tick();
        end
        chk("rstwr.no_wr_rs", 64'(n_wr_rs), 64'd0);
        chk("rstwr.no_done", 64'(n_done), 64'd0);
        for (int i = 0; i < 200 && mem_busy; i++) tick();
        chk("rstwr.mem_kept", 64'(core_rd(18'o300)), 64'(ref_rd(18'o300)));

        for (int k = 0; k < 40; k++) begin
            logic [1:0]   op;
            logic [18:35] a;
            op = 2'($urandom_range(1, 3));
            a  = pool[$urandom_range(0, 7)];
            run_txn(op, a, rnd36(), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 5), "rnd");
        end

        chk("bus_zero_outside_req", 64'(bus_viol), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
